// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for an NUM_STAGES-buffer CPU pipeline.
//   Buffer 0 is IF_ID, then ID_EX, EX_MEM, MEM_WB, ...
//   Drives per-buffer stall/flush combinationally in the same cycle, holds
//   a registered multi-cycle load-use bubble sequence, and optionally keeps
//   saturating performance counters.
//
//   Optional feature macro: HAZARD_PERF_EN (enables the stall/flush counters;
//   when undefined both counter outputs are tied to zero and no flops exist).
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   alert            in   interrupt/alert redirect (flushes IF_ID)
//   branch_miss      in   branch mispredict
//   mem_stall        in   memory not ready (level)
//   load_hazard      in   load-use dependency detected in decode
//   branch_call_jump in   taken call/jump resolved in decode
//   stall            out  per-buffer hold enable
//   flush            out  per-buffer bubble insert
//   load_hold        out  load-use hold sequence active
//   stall_cycles     out  cycles with any stall bit set
//   flush_events     out  cycles with any flush bit set
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_STAGES         = 4,
  parameter int unsigned LOAD_STALL_CYCLES  = 1,
  parameter int unsigned BRANCH_FLUSH_DEPTH = 3,
  parameter int unsigned JUMP_FLUSH_DEPTH   = 2,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alert,
  input  logic                  branch_miss,
  input  logic                  mem_stall,
  input  logic                  load_hazard,
  input  logic                  branch_call_jump,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  load_hold,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam logic [NUM_STAGES-1:0] ALL_MASK   = '1;
  localparam logic [NUM_STAGES-1:0] BR_MASK    = ALL_MASK >> (NUM_STAGES - BRANCH_FLUSH_DEPTH);
  localparam logic [NUM_STAGES-1:0] JMP_MASK   = ALL_MASK >> (NUM_STAGES - JUMP_FLUSH_DEPTH);
  // Load-use holds everything upstream of the last buffer; MEM_WB drains a bubble.
  localparam logic [NUM_STAGES-1:0] LOAD_MASK  = ALL_MASK >> 1;
  localparam logic [NUM_STAGES-1:0] ALERT_MASK = NUM_STAGES'(1);
  localparam logic [3:0]            HOLD_INIT  = 4'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [0:0] {RUN, LOAD_HOLD} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    stall   = '0;
    flush   = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      flush = '1;
    end else if (alert) begin
      flush   = ALERT_MASK;
      state_d = RUN;
      cnt_d   = '0;
    end else if (branch_miss) begin
      flush   = BR_MASK;
      state_d = RUN;
      cnt_d   = '0;
    end else if (mem_stall) begin
      // Whole pipe frozen; the hold counter does not advance.
      stall = '1;
    end else if (state_q == LOAD_HOLD || load_hazard) begin
      stall = LOAD_MASK;
      if (state_q == LOAD_HOLD) begin
        // A fresh load_hazard here does not reload the count.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        // This cycle is the first bubble; the remaining ones are counted.
        state_d = LOAD_HOLD;
        cnt_d   = HOLD_INIT;
      end
    end else if (branch_call_jump) begin
      flush = JMP_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_hold = (state_q == LOAD_HOLD) && !rst;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if ((|stall) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if ((|flush) && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
